mem_arbiter: RTL

Single-port memory controller that shares the byte-wide RAM between instruction fetch (IF) and the load/store unit fed by the LS buffer. It arbitrates between the two requesters and latches the granted request. It then sequences the 1/2/4-byte transfer one byte per cycle, packs read bytes little-endian and returns a one-cycle ack with the data. At most one transfer is in flight.

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller sharing one byte-wide RAM between instruction fetch and the LS unit.
// Optional round-robin conflict resolution is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_ack,
    output logic [31:0]           ls_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_TAIL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Handshake: a requester holds req high with stable operands until its
    // one-cycle ack; requests are only sampled in IDLE, so an ack is always
    // followed by at least one IDLE cycle before the next grant.

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            last_q, last_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  gnt_ls_q, gnt_ls_d;
    logic                  last_grant_ls_q, last_grant_ls_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic                  if_ack_q, if_ack_d;
    logic                  ls_ack_q, ls_ack_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  busy_q, busy_d;

    logic                  pick_ls;
    logic [1:0]            prev_idx;

    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            2'd0:    size_last = 2'd0;
            2'd1:    size_last = 2'd1;
            default: size_last = 2'd3;
        endcase
    endfunction

`ifdef MEM_ARB_RR_EN
    assign pick_ls = ls_req && (!if_req || !last_grant_ls_q);
`else
    assign pick_ls = ls_req;
`endif

    assign prev_idx = cnt_q - 2'd1;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_d          = last_q;
        base_d          = base_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        gnt_ls_d        = gnt_ls_q;
        last_grant_ls_d = last_grant_ls_q;
        rbuf_d          = rbuf_q;
        if_ack_d        = 1'b0;
        ls_ack_d        = 1'b0;
        if_data_d       = if_data_q;
        ls_rdata_d      = ls_rdata_q;
        ram_addr_d      = ram_addr_q;
        ram_we_d        = 1'b0;
        ram_dout_d      = ram_dout_q;

        case (state_q)
            S_IDLE: begin
                ram_addr_d = '0;
                if (if_req || ls_req) begin
                    gnt_ls_d        = pick_ls;
                    last_grant_ls_d = pick_ls;
                    base_d          = pick_ls ? ls_addr : if_addr;
                    we_d            = pick_ls && ls_we;
                    wdata_d         = pick_ls ? ls_wdata : 32'h0;
                    last_d          = pick_ls ? size_last(ls_size) : 2'd3;
                    cnt_d           = 2'd0;
                    rbuf_d          = 32'h0;
                    // Outputs are registered, so byte 0 goes out on the grant edge.
                    ram_addr_d      = base_d;
                    ram_we_d        = we_d;
                    ram_dout_d      = wdata_d[7:0];
                    state_d         = S_XFER;
                end
            end
            S_XFER: begin
                if (!we_q && cnt_q != 2'd0) begin
                    rbuf_d[{prev_idx, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q == last_q) begin
                    if (we_q) begin
                        state_d  = S_DONE;
                        ls_ack_d = gnt_ls_q;
                        if_ack_d = !gnt_ls_q;
                    end else begin
                        state_d = S_TAIL;
                    end
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    ram_addr_d = base_q + ADDR_WIDTH'(cnt_d);
                    ram_we_d   = we_q;
                    ram_dout_d = wdata_q[{cnt_d, 3'b000} +: 8];
                end
            end
            S_TAIL: begin
                rbuf_d[{last_q, 3'b000} +: 8] = ram_din;
                state_d = S_DONE;
                if (gnt_ls_q) begin
                    ls_ack_d   = 1'b1;
                    ls_rdata_d = rbuf_d;
                end else begin
                    if_ack_d  = 1'b1;
                    if_data_d = rbuf_d;
                end
            end
            S_DONE: begin
                ram_addr_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 2'd0;
            last_q          <= 2'd0;
            base_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= 32'h0;
            gnt_ls_q        <= 1'b0;
            last_grant_ls_q <= 1'b0;
            rbuf_q          <= 32'h0;
            if_ack_q        <= 1'b0;
            ls_ack_q        <= 1'b0;
            if_data_q       <= 32'h0;
            ls_rdata_q      <= 32'h0;
            ram_addr_q      <= '0;
            ram_we_q        <= 1'b0;
            ram_dout_q      <= 8'h0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_q          <= last_d;
            base_q          <= base_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            gnt_ls_q        <= gnt_ls_d;
            last_grant_ls_q <= last_grant_ls_d;
            rbuf_q          <= rbuf_d;
            if_ack_q        <= if_ack_d;
            ls_ack_q        <= ls_ack_d;
            if_data_q       <= if_data_d;
            ls_rdata_q      <= ls_rdata_d;
            ram_addr_q      <= ram_addr_d;
            ram_we_q        <= ram_we_d;
            ram_dout_q      <= ram_dout_d;
            busy_q          <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_data   = if_data_q;
    assign ls_ack    = ls_ack_q;
    assign ls_rdata  = ls_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_dout  = ram_dout_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
